// File: rtl/stream_demux_reg.sv
// Registered 1-to-N valid/ready demultiplexer with a single-entry holding slot per channel.
// Define STREAM_DEMUX_REG_DROP_CNT_EN to add a saturating drop_cnt of discarded out-of-range beats.
module stream_demux_reg #(
  parameter  int N_OUT = 4,
  parameter  int W     = 8,
  localparam int SW    = $clog2(N_OUT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SW-1:0]        in_sel,
  input  logic [W-1:0]         in_data,
  output logic [N_OUT-1:0]     out_valid,
  input  logic [N_OUT-1:0]     out_ready,
  output logic [N_OUT*W-1:0]   out_data,
  output logic                 sel_err
`ifdef STREAM_DEMUX_REG_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  localparam logic [SW:0] NOUT_C = (SW+1)'(N_OUT);

  logic [N_OUT-1:0]   valid_q, valid_d;
  logic [N_OUT*W-1:0] data_q, data_d;
  logic               sel_err_q, sel_err_d;
  logic [N_OUT-1:0]   slot_free;
  logic               sel_legal;
  logic               sel_free;
  logic               accept;

  assign sel_legal = ({1'b0, in_sel} < NOUT_C);
  assign slot_free = ~valid_q | out_ready;

  // Mux keeps out_ready[j] out of in_ready unless in_sel selects j.
  always_comb begin
    sel_free = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (in_sel == SW'(i)) sel_free = slot_free[i];
    end
  end

  assign in_ready = rst_n && (!sel_legal || sel_free);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    sel_err_d = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (valid_q[i] && out_ready[i]) valid_d[i] = 1'b0;
      if (accept && sel_legal && (in_sel == SW'(i))) begin
        valid_d[i]         = 1'b1;
        data_d[i*W +: W]   = in_data;
      end
    end
    if (accept && !sel_legal) sel_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      data_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign sel_err   = sel_err_q;

`ifdef STREAM_DEMUX_REG_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (accept && !sel_legal && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_stream_demux_reg.sv
// Bench for stream_demux_reg: per-channel occupancy model checked every cycle plus directed literal checks.
// A second 3-channel instance exercises out-of-range selects.
module tb_stream_demux_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;
  logic        sel_err;

  logic        i3_valid, i3_ready;
  logic [1:0]  i3_sel;
  logic [7:0]  i3_data;
  logic [2:0]  o3_valid, o3_ready;
  logic [23:0] o3_data;
  logic        err3;
`ifdef STREAM_DEMUX_REG_DROP_CNT_EN
  logic [15:0] drop4, drop3;
`endif

  stream_demux_reg #(.N_OUT(4), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel_err(sel_err)
`ifdef STREAM_DEMUX_REG_DROP_CNT_EN
    , .drop_cnt(drop4)
`endif
  );

  stream_demux_reg #(.N_OUT(3), .W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(i3_valid), .in_ready(i3_ready), .in_sel(i3_sel), .in_data(i3_data),
    .out_valid(o3_valid), .out_ready(o3_ready), .out_data(o3_data),
    .sel_err(err3)
`ifdef STREAM_DEMUX_REG_DROP_CNT_EN
    , .drop_cnt(drop3)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cnt50 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: each channel is either empty or holds one beat; the shown data is the last beat loaded.
  bit         m_full [4];
  logic [7:0] m_data [4];
  bit         m_err;
  bit         m_acc;

  function automatic logic model_ready();
    if (!rst_n) return 1'b0;
    return !m_full[in_sel] || out_ready[in_sel];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        m_full[c] = 1'b0;
        m_data[c] = 8'h00;
      end
      m_err = 1'b0;
    end else begin
      m_acc = in_valid && model_ready();
      for (int c = 0; c < 4; c++)
        if (m_full[c] && out_ready[c]) m_full[c] = 1'b0;
      if (m_acc) begin
        m_full[in_sel] = 1'b1;
        m_data[in_sel] = in_data;
      end
      m_err = 1'b0;
    end
  end

  always @(negedge clk) begin : cmp_p
    logic [3:0] ev;
    for (int c = 0; c < 4; c++) ev[c] = m_full[c];
    chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
    chk("out_valid", {28'b0, out_valid}, {28'b0, ev});
    for (int c = 0; c < 4; c++)
      chk("out_data", {24'b0, out_data[c*8 +: 8]}, {24'b0, m_data[c]});
    chk("sel_err", {31'b0, sel_err}, {31'b0, m_err});
    if (rst_n && out_valid[2] && out_ready[2] && out_data[23:16] == 8'h50) cnt50++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [1:0] s, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 4'h0;
    beat(1'b1, 2'd1, 8'hAA);
    i3_valid = 1'b0; i3_sel = 2'd0; i3_data = 8'h00; o3_ready = 3'b111;

    // reset hold
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 0);
      chk("rst_out_valid", {28'b0, out_valid}, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sel_err", {31'b0, sel_err}, 0);
      cyc();
    end
    rst_n = 1'b1;
    @(negedge clk); chk("rel_in_ready", {31'b0, in_ready}, 1);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("rel_valid", {28'b0, out_valid}, 32'h2);
    chk("rel_data1", {24'b0, out_data[15:8]}, 32'hAA);
    out_ready = 4'hF; cyc();
    @(negedge clk); chk("rel_drained", {28'b0, out_valid}, 0);

    // basic routing
    beat(1'b1, 2'd0, 8'h11);
    @(negedge clk); chk("rt_rdy0", {31'b0, in_ready}, 1);
    cyc(); beat(1'b1, 2'd3, 8'h22);
    @(negedge clk);
    chk("rt_rdy1", {31'b0, in_ready}, 1);
    chk("rt_v0", {28'b0, out_valid}, 32'h1);
    chk("rt_d0", {24'b0, out_data[7:0]}, 32'h11);
    cyc(); beat(1'b1, 2'd2, 8'h33);
    @(negedge clk);
    chk("rt_v3", {28'b0, out_valid}, 32'h8);
    chk("rt_d3", {24'b0, out_data[31:24]}, 32'h22);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("rt_v2", {28'b0, out_valid}, 32'h4);
    chk("rt_d2", {24'b0, out_data[23:16]}, 32'h33);
    cyc();

    // backpressure isolation
    out_ready = 4'b1101; beat(1'b1, 2'd1, 8'h40);
    @(negedge clk); chk("bp_rdy40", {31'b0, in_ready}, 1);
    cyc(); beat(1'b1, 2'd1, 8'h41);
    @(negedge clk);
    chk("bp_rdy41", {31'b0, in_ready}, 0);
    chk("bp_v1", {28'b0, out_valid}, 32'h2);
    chk("bp_d40", {24'b0, out_data[15:8]}, 32'h40);
    cyc();
    @(negedge clk);
    chk("bp_rdy41b", {31'b0, in_ready}, 0);
    chk("bp_hold40", {24'b0, out_data[15:8]}, 32'h40);
    cyc(); out_ready = 4'hF;
    @(negedge clk); chk("bp_rdy_rel", {31'b0, in_ready}, 1);
    cyc(); out_ready = 4'b1101; beat(1'b1, 2'd0, 8'h42);
    @(negedge clk);
    chk("bp_nobubble", {28'b0, out_valid}, 32'h2);
    chk("bp_d41", {24'b0, out_data[15:8]}, 32'h41);
    chk("bp_rdy42", {31'b0, in_ready}, 1);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("bp_v01", {28'b0, out_valid}, 32'h3);
    chk("bp_d42", {24'b0, out_data[7:0]}, 32'h42);
    out_ready = 4'hF; cyc();

    // simultaneous drain and load
    out_ready = 4'b1011; beat(1'b1, 2'd2, 8'h50);
    cyc(); in_valid = 1'b0;
    @(negedge clk); chk("dl_d50", {24'b0, out_data[23:16]}, 32'h50);
    cyc(); out_ready = 4'hF; beat(1'b1, 2'd2, 8'h51);
    @(negedge clk); chk("dl_rdy", {31'b0, in_ready}, 1);
    cyc(); in_valid = 1'b0; out_ready = 4'b1011;
    @(negedge clk);
    chk("dl_v2", {28'b0, out_valid}, 32'h4);
    chk("dl_d51", {24'b0, out_data[23:16]}, 32'h51);
    chk("dl_once50", cnt50, 1);
    out_ready = 4'hF; cyc();

    // full throughput on one channel
    beat(1'b1, 2'd1, 8'h70);
    cyc(); beat(1'b1, 2'd1, 8'h71);
    @(negedge clk); chk("tp_d70", {24'b0, out_data[15:8]}, 32'h70);
    cyc(); beat(1'b1, 2'd1, 8'h72);
    @(negedge clk); chk("tp_d71", {24'b0, out_data[15:8]}, 32'h71);
    cyc(); in_valid = 1'b0;
    @(negedge clk); chk("tp_d72", {24'b0, out_data[15:8]}, 32'h72);
    cyc();

    // reset mid-operation
    out_ready = 4'h0;
    for (int k = 0; k < 4; k++) begin
      beat(1'b1, 2'(k), 8'(8'h60 + k));
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("rm_full", {28'b0, out_valid}, 32'hF);
    chk("rm_data", out_data, 32'h63626160);
    cyc(); rst_n = 1'b0;
    @(negedge clk); chk("rm_rdy_rst", {31'b0, in_ready}, 0);
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("rm_cleared", {28'b0, out_valid}, 0);
    chk("rm_data0", out_data, 0);
    out_ready = 4'hF;
    repeat (2) cyc();
    @(negedge clk); chk("rm_no_reappear", {28'b0, out_valid}, 0);

    // illegal select on the 3-channel instance
    @(negedge clk);
    chk("il_err_idle", {31'b0, err3}, 0);
`ifdef STREAM_DEMUX_REG_DROP_CNT_EN
    chk("il_drop0", {16'b0, drop3}, 0);
`endif
    cyc(); i3_valid = 1'b1; i3_sel = 2'd3; i3_data = 8'hEE;
    @(negedge clk); chk("il_rdy", {31'b0, i3_ready}, 1);
    cyc(); i3_valid = 1'b0;
    @(negedge clk);
    chk("il_err1", {31'b0, err3}, 1);
    chk("il_valid", {29'b0, o3_valid}, 0);
`ifdef STREAM_DEMUX_REG_DROP_CNT_EN
    chk("il_drop1", {16'b0, drop3}, 1);
    chk("il_drop4", {16'b0, drop4}, 0);
`endif
    cyc();
    @(negedge clk);
    chk("il_err_once", {31'b0, err3}, 0);
    chk("il_valid2", {29'b0, o3_valid}, 0);
`ifdef STREAM_DEMUX_REG_DROP_CNT_EN
    chk("il_drop_hold", {16'b0, drop3}, 1);
`endif
    cyc(); i3_valid = 1'b1; i3_sel = 2'd2; i3_data = 8'h5A;
    cyc(); i3_valid = 1'b0;
    @(negedge clk);
    chk("il_legal_v", {29'b0, o3_valid}, 32'h4);
    chk("il_legal_d", {24'b0, o3_data[23:16]}, 32'h5A);
    chk("il_legal_err", {31'b0, err3}, 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
